vend_txn_controller: RTL and testbench

//  Transaction sequencer for the vending-machine datapath: edge-detects coin/accept inputs,

---
 rtl/vend_pkg.sv | 29 ++
 rtl/vend_edge_det.sv | 31 +++
 rtl/vend_txn_controller.sv | 164 ++++++++++++++++
 tb/tb_vend_txn_controller.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vend_pkg
// Brief    : Shared state encoding and default sizing for the vending sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package vend_pkg;

    localparam int VEND_CREDIT_W = 3;
    localparam int VEND_PROD_W   = 3;
    localparam int VEND_PRICE    = 3;
    localparam int VEND_TIMEOUT  = 255;
    localparam int VEND_TMR_W    = 10;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COLLECT   = 3'd1,
        ST_VEND_REQ  = 3'd2,
        ST_VEND_WAIT = 3'd3,
        ST_CHANGE    = 3'd4,
        ST_ERROR     = 3'd5
    } vend_state_t;

    function automatic logic vend_is_busy(input vend_state_t s);
        return (s == ST_VEND_REQ) || (s == ST_VEND_WAIT) || (s == ST_CHANGE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vend_edge_det.sv
`default_nettype none
// ============================================================================
// Module   : vend_edge_det
// Brief    : Registered rising-edge detector; pulse appears one clock after the
//            input is first seen high.
// Revision : 1.0 - initial release
// ============================================================================
module vend_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic rise_o
);

    logic prev_q;
    logic rise_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            prev_q <= sig_i;
            rise_q <= sig_i & ~prev_q;
        end
    end

    assign rise_o = rise_q;

endmodule
`default_nettype wire

// File: rtl/vend_txn_controller.sv
`default_nettype none
// ============================================================================
// Module   : vend_txn_controller
// Brief    : Vending transaction sequencer: credit register, price check and
//            four-phase req/ack handshake to the dispenser. Optional change
//            return is built when CHANGE_RETURN_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module vend_txn_controller
    import vend_pkg::*;
#(
    parameter int CREDIT_W = VEND_CREDIT_W,
    parameter int PRICE    = VEND_PRICE,
    parameter int PROD_W   = VEND_PROD_W,
    parameter int TIMEOUT  = VEND_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_i,
    input  logic                accept_i,
    input  logic [PROD_W-1:0]   prod_sel_i,
    input  logic                disp_ack_i,
    output logic                disp_req_o,
    output logic [PROD_W-1:0]   disp_prod_o,
    output logic [CREDIT_W-1:0] credit_o,
    output logic                coin_rej_o,
    output logic                busy_o,
    output logic                err_o,
    output logic                change_o
);

    localparam logic [CREDIT_W-1:0]   C_PRICE   = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0]   C_MAX     = {CREDIT_W{1'b1}};
    localparam logic [CREDIT_W-1:0]   C_ONE     = CREDIT_W'(1);
    localparam logic [VEND_TMR_W-1:0] C_TO_LAST = VEND_TMR_W'(TIMEOUT - 1);
    localparam logic [VEND_TMR_W-1:0] C_TMR_ONE = VEND_TMR_W'(1);

    logic coin_rise;
    logic accept_rise;

    vend_state_t           state_q;
    logic [CREDIT_W-1:0]   credit_q;
    logic [PROD_W-1:0]     prod_q;
    logic [VEND_TMR_W-1:0] tmr_q;
    logic                  req_q;
    logic                  rej_q;
    logic                  err_q;
`ifdef CHANGE_RETURN_EN
    logic                  change_q;
`endif

    vend_edge_det u_coin_det (
        .clk    (clk),
        .rst    (rst),
        .sig_i  (coin_i),
        .rise_o (coin_rise)
    );

    vend_edge_det u_accept_det (
        .clk    (clk),
        .rst    (rst),
        .sig_i  (accept_i),
        .rise_o (accept_rise)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            credit_q <= '0;
            prod_q   <= '0;
            tmr_q    <= '0;
            req_q    <= 1'b0;
            rej_q    <= 1'b0;
            err_q    <= 1'b0;
`ifdef CHANGE_RETURN_EN
            change_q <= 1'b0;
`endif
        end else begin
            rej_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (coin_rise) begin
                        credit_q <= C_ONE;
                        state_q  <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (coin_rise) begin
                        if (credit_q == C_MAX) rej_q    <= 1'b1;
                        else                   credit_q <= credit_q + C_ONE;
                    end
                    // Price check uses the credit held before any coin counted this cycle.
                    if (accept_rise && (credit_q >= C_PRICE)) begin
                        prod_q  <= prod_sel_i;
                        req_q   <= 1'b1;
                        tmr_q   <= '0;
                        state_q <= ST_VEND_REQ;
                    end
                end
                ST_VEND_REQ: begin
                    rej_q <= coin_rise;
                    if (disp_ack_i) begin
                        req_q   <= 1'b0;
                        state_q <= ST_VEND_WAIT;
                        if (credit_q >= C_PRICE) credit_q <= credit_q - C_PRICE;
                    end else if (tmr_q == C_TO_LAST) begin
                        req_q   <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= ST_ERROR;
                    end else begin
                        tmr_q <= tmr_q + C_TMR_ONE;
                    end
                end
                ST_VEND_WAIT: begin
                    rej_q <= coin_rise;
                    if (!disp_ack_i) begin
                        if (credit_q == '0) begin
                            state_q <= ST_IDLE;
                        end else begin
`ifdef CHANGE_RETURN_EN
                            state_q <= ST_CHANGE;
`else
                            state_q <= ST_COLLECT;
`endif
                        end
                    end
                end
`ifdef CHANGE_RETURN_EN
                ST_CHANGE: begin
                    rej_q <= coin_rise;
                    // One credit unit per high cycle, always followed by a low cycle.
                    if (!change_q) begin
                        change_q <= 1'b1;
                        credit_q <= credit_q - C_ONE;
                    end else begin
                        change_q <= 1'b0;
                        if (credit_q == '0) state_q <= ST_IDLE;
                    end
                end
`endif
                ST_ERROR: begin
                    rej_q <= coin_rise;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign disp_req_o  = req_q;
    assign disp_prod_o = prod_q;
    assign credit_o    = credit_q;
    assign coin_rej_o  = rej_q;
    assign busy_o      = vend_is_busy(state_q);
    assign err_o       = err_q;
`ifdef CHANGE_RETURN_EN
    assign change_o    = change_q;
`else
    assign change_o    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vend_txn_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_vend_txn_controller
// Brief    : Directed self-checking bench for vend_txn_controller with a
//            phase-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vend_txn_controller;

    localparam int CW    = 3;
    localparam int PRICE = 3;
    localparam int PW    = 3;
    localparam int TO    = 255;
    localparam int CMAX  = 7;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          coin_i = 1'b0;
    logic          accept_i = 1'b0;
    logic          disp_ack_i = 1'b0;
    logic [PW-1:0] prod_sel_i = '0;
    logic          disp_req_o;
    logic [PW-1:0] disp_prod_o;
    logic [CW-1:0] credit_o;
    logic          coin_rej_o;
    logic          busy_o;
    logic          err_o;
    logic          change_o;

    always #5 clk = ~clk;

    vend_txn_controller #(
        .CREDIT_W (CW),
        .PRICE    (PRICE),
        .PROD_W   (PW),
        .TIMEOUT  (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .coin_i      (coin_i),
        .accept_i    (accept_i),
        .prod_sel_i  (prod_sel_i),
        .disp_ack_i  (disp_ack_i),
        .disp_req_o  (disp_req_o),
        .disp_prod_o (disp_prod_o),
        .credit_o    (credit_o),
        .coin_rej_o  (coin_rej_o),
        .busy_o      (busy_o),
        .err_o       (err_o),
        .change_o    (change_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: shopping / vending / releasing / returning change / error.
    typedef enum int {P_SHOP, P_VEND, P_REL, P_CHG, P_ERR} phase_t;
    phase_t m_phase;
    int     m_credit, m_wait, m_prod, m_before;
    bit     m_rej, m_chg;
    bit     m_cprev, m_aprev, m_cevt, m_aevt, m_ce, m_ae;
    int     chg_q[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = P_SHOP; m_credit = 0; m_wait = 0; m_prod = 0;
            m_rej = 0; m_chg = 0;
            m_cprev = 0; m_aprev = 0; m_cevt = 0; m_aevt = 0;
            chg_q.delete();
        end else begin
            m_ce = m_cevt;
            m_ae = m_aevt;
            m_cevt = coin_i & ~m_cprev;
            m_aevt = accept_i & ~m_aprev;
            m_cprev = coin_i;
            m_aprev = accept_i;
            m_rej = 0;
            m_chg = 0;
            case (m_phase)
                P_SHOP: begin
                    m_before = m_credit;
                    if (m_ce) begin
                        if (m_credit == CMAX) m_rej = 1;
                        else m_credit++;
                    end
                    if (m_ae && m_before >= PRICE) begin
                        m_prod = int'(prod_sel_i);
                        m_wait = 0;
                        m_phase = P_VEND;
                    end
                end
                P_VEND: begin
                    m_rej = m_ce;
                    if (disp_ack_i) begin
                        m_credit -= PRICE;
                        m_phase = P_REL;
                    end else begin
                        m_wait++;
                        if (m_wait == TO) m_phase = P_ERR;
                    end
                end
                P_REL: begin
                    m_rej = m_ce;
                    if (!disp_ack_i) begin
`ifdef CHANGE_RETURN_EN
                        if (m_credit > 0) begin
                            for (int i = 0; i < m_credit; i++) begin
                                chg_q.push_back(1);
                                chg_q.push_back(0);
                            end
                            m_phase = P_CHG;
                        end else begin
                            m_phase = P_SHOP;
                        end
`else
                        m_phase = P_SHOP;
`endif
                    end
                end
                P_CHG: begin
                    m_rej = m_ce;
                    m_chg = (chg_q.pop_front() != 0);
                    if (m_chg) m_credit--;
                    if (chg_q.size() == 0) m_phase = P_SHOP;
                end
                default: begin
                    m_rej = m_ce;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("credit", credit_o, m_credit);
            check("disp_req", disp_req_o, m_phase == P_VEND);
            if (m_phase == P_VEND) check("disp_prod", disp_prod_o, m_prod);
            check("coin_rej", coin_rej_o, m_rej);
            check("busy", busy_o, m_phase == P_VEND || m_phase == P_REL || m_phase == P_CHG);
            check("err", err_o, m_phase == P_ERR);
            check("change", change_o, m_chg);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic coin();
        coin_i = 1'b1; tick();
        coin_i = 1'b0; tick();
    endtask

    task automatic accept(input int p);
        prod_sel_i = PW'(p);
        accept_i = 1'b1; tick();
        accept_i = 1'b0; tick();
    endtask

    task automatic handshake();
        disp_ack_i = 1'b1; tick();
        disp_ack_i = 1'b0; tick();
    endtask

    task automatic do_reset();
        rst = 1'b1; tick(); tick();
        rst = 1'b0;
    endtask

    initial begin
        int pulses;
        repeat (2) tick();
        check("rst_credit", credit_o, 0);
        check("rst_req", disp_req_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_err", err_o, 0);
        check("rst_rej", coin_rej_o, 0);
        check("rst_change", change_o, 0);
        rst = 1'b0;

        // Basic three-coin purchase with delayed ack
        repeat (3) coin();
        check("t1_credit3", credit_o, 3);
        accept(5);
        check("t1_req", disp_req_o, 1);
        check("t1_prod", disp_prod_o, 5);
        check("t1_busy", busy_o, 1);
        repeat (4) tick();
        check("t1_req_held", disp_req_o, 1);
        disp_ack_i = 1'b1; tick();
        check("t1_req_drop", disp_req_o, 0);
        check("t1_credit0", credit_o, 0);
        disp_ack_i = 1'b0; tick();
        check("t1_idle", busy_o, 0);

        // Insufficient credit, then enough
        repeat (2) coin();
        accept(1);
        check("t2_noreq", disp_req_o, 0);
        check("t2_credit2", credit_o, 2);
        coin();
        accept(2);
        check("t2_req", disp_req_o, 1);
        check("t2_prod", disp_prod_o, 2);
        handshake();
        check("t2_credit0", credit_o, 0);

        // Saturation at CREDIT_MAX
        do_reset();
        repeat (7) coin();
        check("t3_credit7", credit_o, 7);
        check("t3_norej", coin_rej_o, 0);
        coin();
        check("t3_rej", coin_rej_o, 1);
        check("t3_sat", credit_o, 7);
        tick();
        check("t3_rej_pulse", coin_rej_o, 0);

        // Same-cycle coin and accept
        do_reset();
        repeat (2) coin();
        prod_sel_i = 3'd3;
        coin_i = 1'b1; accept_i = 1'b1; tick();
        coin_i = 1'b0; accept_i = 1'b0; tick();
        check("t5_credit3", credit_o, 3);
        check("t5_noreq", disp_req_o, 0);
        coin_i = 1'b1; accept_i = 1'b1; tick();
        coin_i = 1'b0; accept_i = 1'b0; tick();
        check("t5_credit4", credit_o, 4);
        check("t5_req", disp_req_o, 1);
        disp_ack_i = 1'b1; tick();
        check("t5_left1", credit_o, 1);
        disp_ack_i = 1'b0;
        repeat (6) tick();
`ifdef CHANGE_RETURN_EN
        check("t5_final", credit_o, 0);
`else
        check("t5_final", credit_o, 1);
`endif

        // Dispenser timeout
        do_reset();
        repeat (3) coin();
        accept(1);
        repeat (TO - 1) tick();
        check("t4_req_before", disp_req_o, 1);
        check("t4_err_before", err_o, 0);
        tick();
        check("t4_err", err_o, 1);
        check("t4_req_off", disp_req_o, 0);
        check("t4_credit", credit_o, 3);
        coin();
        check("t4_rej", coin_rej_o, 1);
        check("t4_credit_kept", credit_o, 3);
        accept(2);
        check("t4_stuck", err_o, 1);

        // Async reset during VEND_REQ, then a 5-coin purchase
        do_reset();
        repeat (3) coin();
        accept(4);
        check("t6_req", disp_req_o, 1);
        #1 rst = 1'b1;
        #1;
        check("t6_async_req", disp_req_o, 0);
        check("t6_async_credit", credit_o, 0);
        tick();
        rst = 1'b0;
        repeat (5) coin();
        check("t6_credit5", credit_o, 5);
        accept(6);
        check("t6_prod", disp_prod_o, 6);
        handshake();
        pulses = 0;
        repeat (8) begin
            tick();
            if (change_o) pulses++;
        end
`ifdef CHANGE_RETURN_EN
        check("t6_pulses", pulses, 2);
        check("t6_credit", credit_o, 0);
`else
        check("t6_pulses", pulses, 0);
        check("t6_credit", credit_o, 2);
`endif
        check("t6_idle", busy_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
